mux_rr_arbiter: RTL
===================

// Module: mux_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one N:1 MUX among NUM_REQ requesters.
//  Drives the MUX select and enable inputs of the MUX_4_1 / MUX_32_1 family.
//  Grants are burst-based: released on Last, on request drop, or on a hold timeout.
//  Inserts one idle (MUX output Z) cycle between consecutive grants.
// PARAMETERS
//  NUM_REQ   4   number of requesters, 2..32; SEL_W = $clog2(NUM_REQ) (localparam)
//  MAX_HOLD  8   max consecutive cycles one grant may last, >=1; CNT_W = $clog2(MAX_HOLD+1)
// PORTS
//  Clock_In        in   1        rising-edge clock
//  Reset_N_In      in   1        asynchronous reset, active-low
//  Arb_Enable_In   in   1        1 = new grants allowed; 0 = current grant completes, no new ones
//  Request_In      in   NUM_REQ  per-requester request level
//  Last_In         in   1        granted requester signals its final cycle
//  Grant_Out       out  NUM_REQ  one-hot grant, registered
//  MUX_Select_Out  out  SEL_W    to MUX Select_In, registered
//  MUX_Enable_Out  out  1        to MUX Enable_In, registered, equals |Grant_Out
//  Busy_Out        out  1        1 while in GRANT state
// BEHAVIOUR
//  Reset (async, Reset_N_In=0): Grant_Out=0, MUX_Select_Out=0, MUX_Enable_Out=0, Busy_Out=0,
//   priority pointer=0, hold counter=0, state=IDLE. Takes effect immediately, even mid-grant.
//  FSM states: IDLE, GRANT.
//  IDLE: if Arb_Enable_In=1 and |Request_In, winner = first set request at index >= pointer,
//   searching cyclically (index NUM_REQ-1 wraps to 0). At the next edge: state=GRANT,
//   Grant_Out=one-hot(winner), MUX_Select_Out=winner, MUX_Enable_Out=1, counter=1.
//   Latency: request sampled at edge k -> grant visible after edge k+1.
//  GRANT: release when any of the following holds at an edge:
//   (a) Request_In[winner]=0, (b) Last_In=1, or (c) counter==MAX_HOLD.
//   On release, at that edge: state=IDLE, Grant_Out=0, MUX_Enable_Out=0, counter=0,
//   pointer = (winner==NUM_REQ-1) ? 0 : winner+1.
//   Otherwise counter increments. Grant length is therefore 1..MAX_HOLD cycles.
//  MUX_Select_Out holds its last value in IDLE; it changes only on a new grant.
//  The IDLE cycle after a release is mandatory; no back-to-back grants, even to another requester.
//  Requests from non-granted requesters are ignored during GRANT. They are evaluated in the next IDLE.
//  Arb_Enable_In=0 during GRANT does not shorten the grant. It only blocks the IDLE->GRANT transition.
//  If several release conditions coincide, a single release occurs with identical results.
//  Last_In is ignored in IDLE.
//  MAX_HOLD=1: every grant lasts exactly 1 cycle.
//  Unused select codes (NUM_REQ not a power of two) are never driven.
// TESTING
//  1 Reset: Reset_N_In=0 mid-grant with Request_In=4'b0100 -> all outputs 0 in the same cycle;
//    after release, the first grant goes to req 2 (pointer=0, search from 0).
//  2 Rotation: Request_In=4'b1111 held, Last_In pulsed on each grant's 2nd cycle ->
//    grant order 0,1,2,3,0; MUX_Select_Out 0,1,2,3,0; one idle cycle between grants.
//  3 Timeout: MAX_HOLD=8, Request_In=4'b0010 held, Last_In=0 ->
//    Grant_Out=4'b0010 for exactly 8 cycles, 1 idle cycle, then re-granted to req 1.
//  4 Wrap/skip: pointer=3, Request_In=4'b0101 -> grant req 0;
//    next arbitration (pointer=1) -> grant req 2.
//  5 Enable gating: Arb_Enable_In=0 during a grant to req 1 -> grant runs to Last_In;
//    then no grant while Arb_Enable_In=0; grant resumes 1 cycle after Arb_Enable_In=1.
//  6 Simultaneous release: Last_In=1 and Request_In[winner]=0 on the same edge ->
//    single release, pointer advanced once, MUX_Enable_Out=0 next cycle.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin burst arbiter driving the select/enable of a shared N:1 MUX; grant appears one edge after the request is sampled.
// No backpressure: a grant ends on Last_In, a request drop or a MAX_HOLD timeout, and is always followed by one idle cycle.
module mux_rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                       Clock_In,
  input  logic                       Reset_N_In,
  input  logic                       Arb_Enable_In,
  input  logic [NUM_REQ-1:0]         Request_In,
  input  logic                       Last_In,
  output logic [NUM_REQ-1:0]         Grant_Out,
  output logic [$clog2(NUM_REQ)-1:0] MUX_Select_Out,
  output logic                       MUX_Enable_Out,
  output logic                       Busy_Out
);

  localparam int SEL_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               en_q, en_d;

  logic               found;
  logic [SEL_W-1:0]   winner;
  logic [SEL_W-1:0]   idx;
  logic               release_now;

  // Cyclic search starting at the priority pointer; idx never exceeds NUM_REQ-1.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = SEL_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && Request_In[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign release_now = !Request_In[sel_q] || Last_In || (cnt_q == CNT_W'(MAX_HOLD));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    en_d    = en_q;
    case (state_q)
      IDLE: begin
        if (Arb_Enable_In && found) begin
          state_d = GRANT;
          sel_d   = winner;
          grant_d = NUM_REQ'(1) << winner;
          en_d    = 1'b1;
          cnt_d   = CNT_W'(1);
        end
      end
      GRANT: begin
        if (release_now) begin
          state_d = IDLE;
          grant_d = '0;
          en_d    = 1'b0;
          cnt_d   = '0;
          ptr_d   = (sel_q == SEL_W'(NUM_REQ - 1)) ? '0 : sel_q + SEL_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      en_q    <= en_d;
    end
  end

  assign Grant_Out      = grant_q;
  assign MUX_Select_Out = sel_q;
  assign MUX_Enable_Out = en_q;
  assign Busy_Out       = (state_q == GRANT);

endmodule
